// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Optional build macro UART_ARB_TIMEOUT_EN adds a stalled-owner lock timeout (LOCK_TIMEOUT cycles).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int PAYLOAD_BITS = 8,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [GW-1:0]                   grant_id,
  output logic                            lock_abort,
  output logic                            tx_en,
  output logic [PAYLOAD_BITS-1:0]         tx_data,
  input  logic                            tx_busy
);

  localparam int IW = GW + 1;

  if (NUM_REQ < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ and LOCK_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE_WAIT, BUSY_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           ptr, owner, sel;
  logic [IW-1:0]           idx;
  logic                    lock, found, accept, abort;
  logic [PAYLOAD_BITS-1:0] sel_data;
  logic                    sel_last;

  // Candidate search: a locked owner excludes everyone else, otherwise scan from ptr+1 with wrap.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    if (lock) begin
      if (req_valid[owner]) begin
        found = 1'b1;
        sel   = owner;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = {1'b0, ptr} + IW'(k);
        if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
        if (!found && req_valid[idx[GW-1:0]]) begin
          found = 1'b1;
          sel   = idx[GW-1:0];
        end
      end
    end
  end

  assign accept = resetn && (state == IDLE) && !tx_busy && found;

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == GW'(i)) begin
        sel_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_last = req_last[i];
        req_ready[i] = accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept)   state_nxt = ISSUE_WAIT;
      ISSUE_WAIT: if (tx_busy)  state_nxt = BUSY_WAIT;
      BUSY_WAIT:  if (!tx_busy) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_en    <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      lock     <= 1'b0;
      owner    <= '0;
      ptr      <= GW'(NUM_REQ - 1);
    end else begin
      tx_en <= accept;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= sel;
        ptr      <= sel;
        owner    <= sel;
        lock     <= ~sel_last;
      end else if (abort) begin
        lock <= 1'b0;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic          stall;

  // Only idle time with a silent owner counts; the transmitter being busy never does.
  assign stall = (state == IDLE) && lock && !req_valid[owner];
  assign abort = stall && (idle_cnt == CW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_cnt   <= '0;
      lock_abort <= 1'b0;
    end else begin
      lock_abort <= abort;
      if (accept || abort) idle_cnt <= '0;
      else if (stall)      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign abort      = 1'b0;
  assign lock_abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter (busy 1 cycle after en, 100 cycles long).
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int PB = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*PB-1:0] req_data;
  logic [0:0]      grant_id;
  logic            lock_abort, tx_en, tx_busy;
  logic [PB-1:0]   tx_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant_id(grant_id), .lock_abort(lock_abort),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  // Requester sources: the initial block appends bytes, the clocked block consumes on ready.
  logic [PB-1:0] src_data [NR][32];
  logic          src_last [NR][32];
  int            src_len  [NR];
  int            src_idx  [NR] = '{0, 0};

  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) src_idx[i] <= src_idx[i] + 1;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (src_idx[i] < src_len[i]);
      req_data[i*PB +: PB] = src_data[i][src_idx[i][4:0]];
      req_last[i]          = src_last[i][src_idx[i][4:0]];
    end
  end

  int   busy_cnt = 0;
  logic busy_force;
  always @(posedge clk) begin
    if (!resetn)       busy_cnt <= 0;
    else if (tx_en)    busy_cnt <= 100;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  logic [PB-1:0] log_data [64];
  logic [0:0]    log_gid  [64];
  int            log_n   = 0;
  int            en_long = 0;
  int            abort_n = 0;
  logic          en_prev = 1'b0;
  always @(posedge clk) begin
    en_prev <= tx_en;
    if (tx_en && en_prev) en_long <= en_long + 1;
    if (tx_en) begin
      log_data[log_n] <= tx_data;
      log_gid[log_n]  <= grant_id;
      log_n           <= log_n + 1;
    end
    if (lock_abort) abort_n <= abort_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [PB-1:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic wait_log(input int n, input string tag);
    int c = 0;
    while (log_n < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(log_n >= n), 1);
  endtask

  task automatic settle();
    repeat (110) @(negedge clk);
  endtask

  initial begin
    int c;
    resetn     = 1'b0;
    busy_force = 1'b0;
    src_len[0] = 0;
    src_len[1] = 0;
    repeat (3) @(negedge clk);

    // Reset values, ready gated while in reset, then single byte from req0
    push(0, 8'hA5, 1'b1);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_abort", lock_abort, 0);
    resetn = 1'b1;
    #1 chk("t1_ready", req_ready, 2'b01);
    @(negedge clk);
    chk("t1_tx_en", tx_en, 1);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_grant", grant_id, 0);
    push(0, 8'hB6, 1'b1);
    #1 chk("t1_issue_ready", req_ready, 0);
    @(negedge clk);
    chk("t1_pulse", tx_en, 0);
    repeat (50) @(negedge clk);
    chk("t1_busy_ready", req_ready, 0);
    chk("t1_log_n", log_n, 1);
    wait_log(2, "t1_timeout");
    chk("t1_second", log_data[1], 8'hB6);
    settle();

    // Both requesters continuously valid from a fresh reset: alternate 0,1,0,1
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    push(0, 8'hC0, 1'b1); push(0, 8'hC1, 1'b1);
    push(1, 8'hD0, 1'b1); push(1, 8'hD1, 1'b1);
    wait_log(6, "t2_timeout");
    chk("t2_d0", log_data[2], 8'hC0); chk("t2_g0", log_gid[2], 0);
    chk("t2_d1", log_data[3], 8'hD0); chk("t2_g1", log_gid[3], 1);
    chk("t2_d2", log_data[4], 8'hC1); chk("t2_g2", log_gid[4], 0);
    chk("t2_d3", log_data[5], 8'hD1); chk("t2_g3", log_gid[5], 1);
    chk("t2_pulse_width", en_long, 0);
    settle();

    // Message lock keeps req1 waiting until req0 sends its last byte
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    push(1, 8'h44, 1'b1);
    wait_log(10, "t3_timeout");
    chk("t3_b0", log_data[6], 8'h11);
    chk("t3_b1", log_data[7], 8'h22);
    chk("t3_b2", log_data[8], 8'h33);
    chk("t3_b3", log_data[9], 8'h44);
    settle();

    // External transmitter use blocks acceptance
    busy_force = 1'b1;
    push(0, 8'h77, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4_blocked_a", req_ready, 0);
    repeat (20) @(negedge clk);
    chk("t4_blocked_b", req_ready, 0);
    busy_force = 1'b0;
    #1 chk("t4_release", req_ready, 2'b01);
    @(negedge clk);
    chk("t4_tx_en", tx_en, 1);
    chk("t4_tx_data", tx_data, 8'h77);
    settle();

    // Reset during BUSY_WAIT with lock held clears the lock
    push(0, 8'h88, 1'b0);
    wait_log(12, "t5_timeout_a");
    repeat (10) @(negedge clk);
    chk("t5_busy", tx_busy, 1);
    resetn = 1'b0;
    push(1, 8'h99, 1'b1);
    #1 chk("t5_rst_ready", req_ready, 0);
    @(negedge clk);
    chk("t5_tx_en", tx_en, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_grant", grant_id, 0);
    resetn = 1'b1;
    #1 chk("t5_req1_ready", req_ready, 2'b10);
    wait_log(13, "t5_timeout_b");
    chk("t5_data", log_data[12], 8'h99);
    chk("t5_gid", log_gid[12], 1);
    settle();

    // Stalled owner: req0 leaves its message open, req1 waits
    push(0, 8'h55, 1'b0);
    wait_log(14, "t6_timeout");
    push(1, 8'h66, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    c = 0;
    while (!lock_abort && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("t6_abort_seen", lock_abort, 1);
    chk("t6_not_before", log_n, 14);
    chk("t6_ready", req_ready, 2'b10);
    @(negedge clk);
    chk("t6_abort_pulse", lock_abort, 0);
    chk("t6_tx_en", tx_en, 1);
    chk("t6_tx_data", tx_data, 8'h66);
`else
    c = 0;
    repeat (300) @(negedge clk);
    chk("t6_never_issued", log_n, 14);
    chk("t6_no_abort", abort_n, 0);
    chk("t6_ready", req_ready, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
